// File: rtl/hbridge_cmd_driver.sv
// H-bridge command driver: synchronises the four-line command bus, decodes a
// per-channel command, and runs two independent channel FSMs that enforce dead
// time on unsafe transitions and soft-start the PWM duty.

module hbridge_channel #(
    parameter int PWM_BITS      = 8,
    parameter int DEADTIME_CYC  = 50000,
    parameter int RAMP_STEP_CYC = 19531
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic [1:0]          cmd,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty_max,
    output logic                p,
    output logic                n,
    output logic                en,
    output logic                deadtime_nxt,
    output logic                brake_nxt
);
    localparam int DT_W   = $clog2(DEADTIME_CYC + 1);
    localparam int RAMP_W = $clog2(RAMP_STEP_CYC + 1);
    localparam logic [DT_W-1:0]   DT_LAST   = DT_W'(DEADTIME_CYC - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYC - 1);

    typedef enum logic [1:0] {
        CMD_COAST = 2'b00,
        CMD_REV   = 2'b01,
        CMD_FWD   = 2'b10,
        CMD_BRAKE = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {ST_COAST, ST_BRAKE, ST_DEADTIME, ST_DRIVE} state_t;
    typedef enum logic {DIR_FWD, DIR_REV} dir_t;

    cmd_t                cmd_e;
    dir_t                cmd_dir;
    logic                drive_cmd;
    state_t              state, state_nxt;
    dir_t                dir, dir_nxt;
    logic [DT_W-1:0]     dt_tmr, dt_tmr_nxt;
    logic [RAMP_W-1:0]   ramp_tmr;
    logic [PWM_BITS-1:0] duty;
    logic                en_cmp;

    assign cmd_e     = cmd_t'(cmd);
    assign cmd_dir   = (cmd_e == CMD_FWD) ? DIR_FWD : DIR_REV;
    assign drive_cmd = (cmd_e == CMD_FWD) || (cmd_e == CMD_REV);

    // State, direction and dead-time timer registers.
    // NOTE: reset is asynchronous so the bridge is released the instant rst_n
    // drops, independent of whether clk1 is running.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_COAST;
            dir    <= DIR_FWD;
            dt_tmr <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, whatever order the statements appear in.
            state  <= state_nxt;
            dir    <= dir_nxt;
            dt_tmr <= dt_tmr_nxt;
        end
    end

    // Next-state logic: brake/coast commands always win over timer expiry.
    always_comb begin
        // NOTE: hold-current defaults first, so no path leaves a variable
        // unassigned and no latch is inferred.
        state_nxt  = state;
        dir_nxt    = dir;
        dt_tmr_nxt = dt_tmr;
        case (state)
            ST_COAST: begin
                if (cmd_e == CMD_BRAKE) begin
                    state_nxt = ST_BRAKE;
                end else if (drive_cmd) begin
                    state_nxt = ST_DRIVE;
                    dir_nxt   = cmd_dir;
                end
            end
            ST_BRAKE: begin
                if (cmd_e == CMD_COAST) begin
                    state_nxt = ST_COAST;
                end else if (drive_cmd) begin
                    state_nxt  = ST_DEADTIME;
                    dir_nxt    = cmd_dir;
                    dt_tmr_nxt = '0;
                end
            end
            ST_DEADTIME: begin
                if (cmd_e == CMD_BRAKE) begin
                    state_nxt = ST_BRAKE;
                end else if (cmd_e == CMD_COAST) begin
                    state_nxt = ST_COAST;
                end else begin
                    // A new direction only retargets; the dead time keeps running.
                    dir_nxt = cmd_dir;
                    if (dt_tmr == DT_LAST) begin
                        state_nxt = ST_DRIVE;
                    end else begin
                        dt_tmr_nxt = dt_tmr + DT_W'(1);
                    end
                end
            end
            ST_DRIVE: begin
                if (cmd_e == CMD_BRAKE) begin
                    state_nxt = ST_BRAKE;
                end else if (cmd_e == CMD_COAST) begin
                    state_nxt = ST_COAST;
                end else if (cmd_dir != dir) begin
                    state_nxt  = ST_DEADTIME;
                    dir_nxt    = cmd_dir;
                    dt_tmr_nxt = '0;
                end
            end
            default: state_nxt = ST_COAST;
        endcase
    end

    // Soft-start ramp: duty climbs only while staying in DRIVE, else restarts at 0.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            duty     <= '0;
            ramp_tmr <= '0;
        end else if (state == ST_DRIVE && state_nxt == ST_DRIVE) begin
            if (duty > duty_max) begin
                duty <= duty_max;
            end else if (ramp_tmr == RAMP_LAST) begin
                ramp_tmr <= '0;
                if (duty < duty_max) begin
                    duty <= duty + PWM_BITS'(1);
                end
            end else begin
                ramp_tmr <= ramp_tmr + RAMP_W'(1);
            end
        end else begin
            duty     <= '0;
            ramp_tmr <= '0;
        end
    end

    // Registered PWM compare so en is glitch-free.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            en_cmp <= 1'b0;
        end else begin
            en_cmp <= (pwm_cnt < duty);
        end
    end

    // Pin drive per state; p and n are only both high in BRAKE.
    always_comb begin
        p  = 1'b0;
        n  = 1'b0;
        en = 1'b0;
        case (state)
            ST_BRAKE: begin
                p  = 1'b1;
                n  = 1'b1;
                en = 1'b1;
            end
            ST_DRIVE: begin
                p  = (dir == DIR_FWD);
                n  = (dir == DIR_REV);
                en = en_cmp;
            end
            default: ;
        endcase
    end

    assign deadtime_nxt = (state_nxt == ST_DEADTIME);
    assign brake_nxt    = (state_nxt == ST_BRAKE);
endmodule

module hbridge_cmd_driver #(
    parameter int PWM_BITS      = 8,
    parameter int DEADTIME_CYC  = 50000,
    parameter int RAMP_STEP_CYC = 19531
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                in_1,
    input  logic                in_2,
    input  logic                in_3,
    input  logic                in_4,
    input  logic [PWM_BITS-1:0] duty_max,
    output logic                a_p,
    output logic                a_n,
    output logic                en_a,
    output logic                b_p,
    output logic                b_n,
    output logic                en_b,
    output logic                busy,
    output logic                braking
);
    logic [3:0]          sync_q1, sync_q2;
    logic [1:0]          cmd_a, cmd_b;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                a_dt_nxt, a_brk_nxt, b_dt_nxt, b_brk_nxt;

    // Two-flop synchroniser on the asynchronous command pins.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {in_4, in_3, in_2, in_1};
            sync_q2 <= sync_q1;
        end
    end

    // Registered decode: A is (in_1,in_2), B is (in_4,in_3).
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cmd_a <= '0;
            cmd_b <= '0;
        end else begin
            cmd_a <= {sync_q2[0], sync_q2[1]};
            cmd_b <= {sync_q2[3], sync_q2[2]};
        end
    end

    // Free-running PWM counter shared by both channels.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Status flags registered from next state so they line up with the pins.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            braking <= 1'b0;
        end else begin
            busy    <= a_dt_nxt | b_dt_nxt;
            braking <= a_brk_nxt | b_brk_nxt;
        end
    end

    hbridge_channel #(
        .PWM_BITS     (PWM_BITS),
        .DEADTIME_CYC (DEADTIME_CYC),
        .RAMP_STEP_CYC(RAMP_STEP_CYC)
    ) u_chan_a (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .cmd         (cmd_a),
        .pwm_cnt     (pwm_cnt),
        .duty_max    (duty_max),
        .p           (a_p),
        .n           (a_n),
        .en          (en_a),
        .deadtime_nxt(a_dt_nxt),
        .brake_nxt   (a_brk_nxt)
    );

    hbridge_channel #(
        .PWM_BITS     (PWM_BITS),
        .DEADTIME_CYC (DEADTIME_CYC),
        .RAMP_STEP_CYC(RAMP_STEP_CYC)
    ) u_chan_b (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .cmd         (cmd_b),
        .pwm_cnt     (pwm_cnt),
        .duty_max    (duty_max),
        .p           (b_p),
        .n           (b_n),
        .en          (en_b),
        .deadtime_nxt(b_dt_nxt),
        .brake_nxt   (b_brk_nxt)
    );
endmodule

// File: tb/tb_hbridge_cmd_driver.sv
// Bench for hbridge_cmd_driver: directed scenarios plus random command traffic,
// every cycle compared with a behavioural model of the channel rules.

module tb_hbridge_cmd_driver;
    localparam int PWM_BITS = 4;
    localparam int DC       = 8;
    localparam int RSC      = 2;
    localparam int PWM_MOD  = 16;

    logic       clk1  = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_1 = 1'b0, in_2 = 1'b0, in_3 = 1'b0, in_4 = 1'b0;
    logic [3:0] duty_max = 4'd15;
    logic       a_p, a_n, en_a, b_p, b_n, en_b, busy, braking;
    logic [7:0] outs;

    int vectors     = 0;
    int miscompares = 0;

    assign outs = {a_p, a_n, en_a, b_p, b_n, en_b, busy, braking};

    always #10 clk1 = ~clk1;

    hbridge_cmd_driver #(
        .PWM_BITS     (PWM_BITS),
        .DEADTIME_CYC (DC),
        .RAMP_STEP_CYC(RSC)
    ) dut (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .in_1    (in_1),
        .in_2    (in_2),
        .in_3    (in_3),
        .in_4    (in_4),
        .duty_max(duty_max),
        .a_p     (a_p),
        .a_n     (a_n),
        .en_a    (en_a),
        .b_p     (b_p),
        .b_n     (b_n),
        .en_b    (en_b),
        .busy    (busy),
        .braking (braking)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {M_COAST, M_BRAKE, M_DEAD, M_DRIVE} mode_e;
    typedef struct {
        mode_e mode;
        bit    fwd;
        int    dead_start; // cycle stamp at which dead time began
        int    duty;
        int    ramp;       // edges spent at the current duty step
        bit    en_q;
    } chan_m;

    chan_m      ma, mb;
    int         pwm_m;
    int         cyc;
    logic [1:0] hist_a[$];
    logic [1:0] hist_b[$];

    function automatic chan_m chan_idle();
        chan_m c;
        c.mode = M_COAST; c.fwd = 1'b1; c.dead_start = 0;
        c.duty = 0; c.ramp = 0; c.en_q = 1'b0;
        return c;
    endfunction

    task automatic model_reset();
        ma = chan_idle();
        mb = chan_idle();
        pwm_m = 0;
        cyc = 0;
        hist_a.delete();
        hist_b.delete();
        repeat (3) begin
            hist_a.push_back(2'b00);
            hist_b.push_back(2'b00);
        end
    endtask

    function automatic chan_m chan_step(chan_m c, logic [1:0] cmd, int dmax, int pwm_old, int t);
        chan_m r = c;
        bit want_fwd = (cmd == 2'b10);
        bit is_drive = (cmd == 2'b10) || (cmd == 2'b01);
        r.en_q = (pwm_old < c.duty);
        case (c.mode)
            M_COAST: begin
                if (cmd == 2'b11) r.mode = M_BRAKE;
                else if (is_drive) begin r.mode = M_DRIVE; r.fwd = want_fwd; end
            end
            M_BRAKE: begin
                if (cmd == 2'b00) r.mode = M_COAST;
                else if (is_drive) begin r.mode = M_DEAD; r.fwd = want_fwd; r.dead_start = t; end
            end
            M_DEAD: begin
                if (cmd == 2'b11) r.mode = M_BRAKE;
                else if (cmd == 2'b00) r.mode = M_COAST;
                else begin
                    r.fwd = want_fwd;
                    if (t - c.dead_start >= DC) r.mode = M_DRIVE;
                end
            end
            default: begin
                if (cmd == 2'b11) r.mode = M_BRAKE;
                else if (cmd == 2'b00) r.mode = M_COAST;
                else if (want_fwd != c.fwd) begin r.mode = M_DEAD; r.fwd = want_fwd; r.dead_start = t; end
            end
        endcase
        if (c.mode == M_DRIVE && r.mode == M_DRIVE) begin
            if (c.duty > dmax) r.duty = dmax;
            else begin
                r.ramp = c.ramp + 1;
                if (r.ramp == RSC) begin
                    r.ramp = 0;
                    if (c.duty < dmax) r.duty = c.duty + 1;
                end
            end
        end else begin
            r.duty = 0;
            r.ramp = 0;
        end
        return r;
    endfunction

    function automatic logic [2:0] chan_pins(chan_m c);
        case (c.mode)
            M_BRAKE: return 3'b111;
            M_DRIVE: return {c.fwd, ~c.fwd, c.en_q};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] model_outs();
        return {chan_pins(ma), chan_pins(mb),
                (ma.mode == M_DEAD) || (mb.mode == M_DEAD),
                (ma.mode == M_BRAKE) || (mb.mode == M_BRAKE)};
    endfunction

    // Advance one clock; the model steps on every edge outside reset.
    task automatic tick();
        logic [1:0] ca, cb;
        @(posedge clk1);
        if (rst_n) begin
            ca = hist_a.pop_front();
            cb = hist_b.pop_front();
            hist_a.push_back({in_1, in_2});
            hist_b.push_back({in_4, in_3});
            ma = chan_step(ma, ca, int'(duty_max), pwm_m, cyc);
            mb = chan_step(mb, cb, int'(duty_max), pwm_m, cyc);
            pwm_m = (pwm_m + 1) % PWM_MOD;
            cyc++;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: got %b want %b", outs, 8'h00);
        end
        tick();
        tick();
        vectors++;
        if (outs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_held: got %b want %b", outs, 8'h00);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
    endtask

    task automatic test_fwd_ramp();
        int en_cnt = 0;
        {in_1, in_2, in_3, in_4} = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL fwd_latency cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
        vectors++;
        if ({a_p, a_n, en_a, b_p, b_n, en_b} !== 6'b100100) begin
            miscompares++;
            $display("FAIL fwd_pins_4cyc: got %b want %b", {a_p, a_n, en_a, b_p, b_n, en_b}, 6'b100100);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL fwd_ramp cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            en_cnt += int'(en_a);
        end
        vectors++;
        if (en_cnt != 15) begin
            miscompares++;
            $display("FAIL fwd_full_duty: en_a high %0d of 16, want 15", en_cnt);
        end
    endtask

    task automatic test_reversal();
        int busy_cnt = 0;
        {in_1, in_2, in_3, in_4} = 4'b0101;
        for (int i = 0; i < 30; i++) begin
            tick();
            busy_cnt += int'(busy);
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL reversal cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
        vectors++;
        if (busy_cnt != DC) begin
            miscompares++;
            $display("FAIL reversal_deadtime: busy for %0d cycles, want %0d", busy_cnt, DC);
        end
    endtask

    task automatic test_brake();
        int busy_cnt = 0;
        {in_1, in_2, in_3, in_4} = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL brake_enter cyc %0d: got %b want %b", i, outs, model_outs());
            end
            if (i == 3) begin
                vectors++;
                if (outs !== 8'b11111101) begin
                    miscompares++;
                    $display("FAIL brake_pins: got %b want %b", outs, 8'b11111101);
                end
            end
        end
        {in_1, in_2, in_3, in_4} = 4'b1001;
        for (int i = 0; i < 25; i++) begin
            tick();
            busy_cnt += int'(busy);
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL brake_exit cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
        vectors++;
        if (busy_cnt != DC) begin
            miscompares++;
            $display("FAIL brake_exit_deadtime: busy for %0d cycles, want %0d", busy_cnt, DC);
        end
    endtask

    task automatic test_deadtime_abort(input logic [1:0] abort_cmd, input string name);
        logic [2:0] want_a;
        want_a = (abort_cmd == 2'b11) ? 3'b111 : 3'b000;
        {in_1, in_2} = 2'b01;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) {in_1, in_2} = abort_cmd;
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b want %b", name, i, outs, model_outs());
            end
        end
        vectors++;
        if ({a_p, a_n, en_a, busy, braking} !== {want_a, 1'b0, abort_cmd == 2'b11}) begin
            miscompares++;
            $display("FAIL %s_exit: got %b want %b", name, {a_p, a_n, en_a, busy, braking},
                     {want_a, 1'b0, abort_cmd == 2'b11});
        end
        {in_1, in_2} = 2'b10;
        for (int i = 0; i < 25; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL %s_recover cyc %0d: got %b want %b", name, i, outs, model_outs());
            end
        end
    endtask

    task automatic test_duty_clamp();
        bit found = 1'b0;
        int en_cnt = 0;
        {in_1, in_2} = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL clamp_coast cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
        {in_1, in_2} = 2'b10;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL clamp_ramp cyc %0d: got %b want %b", i, outs, model_outs());
            end
            found = (ma.mode == M_DRIVE) && (ma.duty == 12);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL clamp_reach12: duty 12 not reached in 100 cycles, got %0d want 12", ma.duty);
        end
        duty_max = 4'd5;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i >= 4) en_cnt += int'(en_a);
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL clamp_low cyc %0d: got %b want %b", i, outs, model_outs());
            end
        end
        vectors++;
        if (en_cnt != 5) begin
            miscompares++;
            $display("FAIL clamp_duty5: en_a high %0d of 16, want 5", en_cnt);
        end
        duty_max = 4'd15;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) {in_1, in_2} = 2'b01;
            for (int i = 0; i < 6; i++) begin
                tick();
                vectors++;
                if (outs !== model_outs()) begin
                    miscompares++;
                    $display("FAIL areset_pre%0d cyc %0d: got %b want %b", k, i, outs, model_outs());
                end
            end
            #5 rst_n = 1'b0;
            #1;
            vectors++;
            if (outs !== 8'h00) begin
                miscompares++;
                $display("FAIL areset_clear%0d: got %b want %b", k, outs, 8'h00);
            end
            model_reset();
            {in_1, in_2, in_3, in_4} = 4'b1001;
            tick();
            tick();
            #3 rst_n = 1'b1;
            for (int i = 0; i < 14; i++) begin
                tick();
                vectors++;
                if (outs !== model_outs()) begin
                    miscompares++;
                    $display("FAIL areset_post%0d cyc %0d: got %b want %b", k, i, outs, model_outs());
                end
                if (i == 3) begin
                    vectors++;
                    if ({a_p, a_n, en_a, b_p, b_n, en_b} !== 6'b100100) begin
                        miscompares++;
                        $display("FAIL areset_restart%0d: got %b want %b", k,
                                 {a_p, a_n, en_a, b_p, b_n, en_b}, 6'b100100);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) {in_1, in_2} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) {in_4, in_3} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) duty_max = 4'($urandom_range(0, 15));
            tick();
            vectors++;
            if (outs !== model_outs()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b want %b", i, outs, model_outs());
            end
            vectors++;
            if ((a_p && a_n && !en_a) || (b_p && b_n && !en_b)) begin
                miscompares++;
                $display("FAIL random_shoot_through cyc %0d: got %b want p&n only with en", i, outs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_ramp();
        test_reversal();
        test_brake();
        test_deadtime_abort(2'b11, "abort_brake");
        test_deadtime_abort(2'b00, "abort_coast");
        test_duty_clamp();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hbridge_cmd_driver.md
Name: hbridge_cmd_driver

Overview:
- Receiving end of the four-line H-bridge command bus (in_1..in_4) driven by the motor/current-sense controller.
- Decodes each motor channel's command (forward, reverse, brake, coast).
- Enforces dead time on unsafe transitions, soft-starts each channel with a duty ramp, and emits the direction and PWM-enable pins that go to the H-bridge IC.
- Two identical channel FSMs share one free-running PWM counter.

Parameters:
- PWM_BITS, 8: width of the PWM counter, duty and duty_max.
- DEADTIME_CYC, 50000: clk1 cycles with all channel outputs low on a reversal or on leaving brake (1 ms at 50 MHz).
- RAMP_STEP_CYC, 19531: clk1 cycles per +1 duty step during soft-start.

Ports:
- clk1 in 1: system clock, 50 MHz.
- rst_n in 1: asynchronous active-low reset.
- in_1 in 1: channel A command bit 1.
- in_2 in 1: channel A command bit 2.
- in_3 in 1: channel B command bit 2.
- in_4 in 1: channel B command bit 1.
- duty_max in PWM_BITS: duty ceiling applied to both channels.
- a_p out 1: channel A H-bridge input P.
- a_n out 1: channel A H-bridge input N.
- en_a out 1: channel A PWM enable.
- b_p out 1: channel B H-bridge input P.
- b_n out 1: channel B H-bridge input N.
- en_b out 1: channel B PWM enable.
- busy out 1: high while either channel is in DEADTIME.
- braking out 1: high while either channel is in BRAKE.

Behaviour:
- Reset: every output 0. Both FSMs go to COAST, duty=0, PWM counter=0, timers=0. Reset is asynchronous; on release, operation resumes from COAST.
- Input sync: each in_x passes through a 2-flop synchronizer, then the decode is registered. A command change reaches the outputs 4 clk1 cycles after the pin changes.
- Decode, channel A as (in_1,in_2) and channel B as (in_4,in_3): 10 = FWD, 01 = REV, 11 = BRAKE, 00 = COAST.
- FSM states per channel: COAST, BRAKE, DEADTIME, DRIVE. Each channel holds a registered target direction dir (FWD/REV).
- COAST: p=n=en=0, duty=0.
  - FWD/REV command: go to DRIVE, set dir.
  - BRAKE command: go to BRAKE.
- BRAKE: p=n=en=1, duty=0.
  - COAST command: go to COAST.
  - FWD/REV command: go to DEADTIME, set dir.
- DEADTIME: p=n=en=0, duty held at 0. The timer counts up to DEADTIME_CYC-1.
  - Timer expiry: go to DRIVE.
  - BRAKE command: go to BRAKE immediately.
  - COAST command: go to COAST immediately.
  - Any FWD/REV command: updates dir without restarting the timer.
- DRIVE: p=(dir==FWD), n=(dir==REV), en = registered (pwm_cnt < duty).
  - Same-direction command: stay in DRIVE.
  - Opposite direction: go to DEADTIME with the timer cleared, duty=0.
  - BRAKE command: go to BRAKE immediately.
  - COAST command: go to COAST.
- Ramp: in DRIVE, the ramp timer counts to RAMP_STEP_CYC-1, then duty increments by 1, saturating at duty_max.
  - If duty_max falls below duty, duty is clamped to duty_max on the next cycle.
  - duty never wraps.
- PWM: pwm_cnt is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
  - duty=0 gives en constantly 0.
  - duty=2^PWM_BITS-1 gives en high for (2^PWM_BITS-1)/2^PWM_BITS of each period.
- Invariant: p and n are never both 1 unless en=1 in BRAKE. The outputs never go directly between FWD and REV drive.
- busy and braking are registered ORs of the two channels' state flags.
- The two channels are fully independent, apart from sharing pwm_cnt and duty_max.

Test Plan (sim parameters: PWM_BITS=4, DEADTIME_CYC=8, RAMP_STEP_CYC=2, duty_max=15):
- Reset, then in=1001 (A FWD, B FWD) → 4 cycles later a_p=b_p=1, a_n=b_n=0, en=0 while duty=0. duty reaches 15 after 30 cycles. en_a is then high 15 of every 16 cycles.
- With A at duty 15 in DRIVE FWD, switch A to 01 → a_p=a_n=en_a=0 and busy=1 for exactly 8 cycles. Then a_n=1 and duty ramps up from 0. Channel B is unaffected.
- Set in=1111 → both channels enter BRAKE within 4 cycles: all p/n/en=1, braking=1. Then in=1001 → 8-cycle DEADTIME, then DRIVE FWD.
- During A DEADTIME (cycle 3), command 11 → BRAKE next cycle. Repeat the test with command 00 → COAST next cycle.
- During A DRIVE at duty 12, lower duty_max to 5 → duty=5 the next cycle, and en_a is high 5 of every 16 cycles.
- Deassert rst_n mid-DEADTIME and mid-DRIVE → all outputs 0 asynchronously. After release with in=1001, both channels restart from COAST to DRIVE with duty 0.
